// File: rtl/register_serial_pkg.sv
// Shared types and defaults for the register serial read-out path.
package register_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_BIT_CYCLES = 1;

endpackage

// File: rtl/serial_bit_timer.sv
// Counts clock cycles within one serial bit period; ticks on the last cycle.
module serial_bit_timer #(
  parameter int bit_cycles = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
  localparam logic [CW-1:0] LAST = CW'(bit_cycles - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = run && (cnt == LAST);

  // cycle counter: wraps at the end of each bit period, held at zero when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (bit_tick) cnt <= '0;
    else if (run)      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/register_serial_reader.sv
// Serializes a handshaken parallel word MSB first with frame strobe,
// optional even-parity bit and a one-cycle completion pulse.
import register_serial_pkg::*;

module register_serial_reader #(
  parameter int width      = DEF_WIDTH,
  parameter int bit_cycles = DEF_BIT_CYCLES,
  parameter bit parity_en  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(width + 1);
  localparam logic [BW-1:0] LASTBIT = BW'(width - 1);

  state_t           state, state_d;
  logic [width-1:0] sr, sr_d;
  logic [BW-1:0]    bcnt, bcnt_d;
  logic             par, par_d;
  logic             ser_out_d, ser_frame_d, done_d;
  logic             hs, run, bit_tick;

  assign in_ready = (state == IDLE) && !reset;
  assign busy     = (state != IDLE);
  assign hs       = in_valid && in_ready;
  assign run      = (state == SHIFT) || (state == PARITY);

  serial_bit_timer #(.bit_cycles(bit_cycles)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (hs),
    .run      (run),
    .bit_tick (bit_tick)
  );

  // next state, next shift/parity contents, and the outputs for the next cycle
  always_comb begin
    state_d = state;
    sr_d    = sr;
    bcnt_d  = bcnt;
    par_d   = par;
    case (state)
      IDLE: if (hs) begin
        state_d = SHIFT;
        sr_d    = in_data;
        bcnt_d  = '0;
        par_d   = ^in_data;
      end
      SHIFT: if (bit_tick) begin
        sr_d   = {sr[width-2:0], 1'b0};
        bcnt_d = bcnt + BW'(1);
        if (bcnt == LASTBIT) state_d = parity_en ? PARITY : DONE;
      end
      PARITY: if (bit_tick) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are derived from the upcoming state
    ser_out_d   = 1'b0;
    ser_frame_d = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      SHIFT:  begin ser_out_d = sr_d[width-1]; ser_frame_d = 1'b1; end
      PARITY: begin ser_out_d = par_d;         ser_frame_d = 1'b1; end
      DONE:   done_d = 1'b1;
      default: ;
    endcase
  end

  // state, datapath and output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      bcnt      <= '0;
      par       <= 1'b0;
      ser_out   <= 1'b0;
      ser_frame <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      bcnt      <= bcnt_d;
      par       <= par_d;
      ser_out   <= ser_out_d;
      ser_frame <= ser_frame_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_register_serial_reader.sv
// Directed bench: default, parity-enabled and 3-cycle-per-bit instances.
module tb_register_serial_reader;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // a_: defaults, p_: parity_en=1, c_: bit_cycles=3
  logic a_valid, a_ready, a_so, a_fr, a_busy, a_done;
  logic p_valid, p_ready, p_so, p_fr, p_busy, p_done;
  logic c_valid, c_ready, c_so, c_fr, c_busy, c_done;
  logic [7:0] a_data, p_data, c_data;

  register_serial_reader dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .ser_out(a_so), .ser_frame(a_fr), .busy(a_busy), .done(a_done));

  register_serial_reader #(.width(8), .bit_cycles(1), .parity_en(1'b1)) dut_p (
    .clk(clk), .reset(reset), .in_valid(p_valid), .in_data(p_data), .in_ready(p_ready),
    .ser_out(p_so), .ser_frame(p_fr), .busy(p_busy), .done(p_done));

  register_serial_reader #(.width(8), .bit_cycles(3), .parity_en(1'b0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .ser_out(c_so), .ser_frame(c_fr), .busy(c_busy), .done(c_done));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 0; p_valid = 0; c_valid = 0;
    a_data = '0; p_data = '0; c_data = '0;
    #2;
    total++;
    if ({a_so, a_fr, a_busy, a_done, a_ready} !== 5'b00000) begin
      bad++; $display("FAIL reset_outs got=%b want=00000", {a_so, a_fr, a_busy, a_done, a_ready});
    end
    @(posedge clk); #1;
    total++;
    if ({a_ready, p_ready, c_ready} !== 3'b000) begin
      bad++; $display("FAIL reset_ready_held got=%b want=000", {a_ready, p_ready, c_ready});
    end
    @(negedge clk); reset = 1'b0;
    tick();
    total++;
    if ({a_ready, p_ready, c_ready, a_busy} !== 4'b1110) begin
      bad++; $display("FAIL reset_release got=%b want=1110", {a_ready, p_ready, c_ready, a_busy});
    end
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'hA5;
    a_valid = 1; a_data = w;
    tick();  // cycle k+1
    a_valid = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({a_so, a_fr, a_done, a_ready} !== {w[7-i], 3'b100}) begin
        bad++; $display("FAIL basic_bit%0d got=%b want=%b", i, {a_so, a_fr, a_done, a_ready}, {w[7-i], 3'b100});
      end
      tick();
    end
    total++;  // k+9
    if ({a_so, a_fr, a_done, a_ready, a_busy} !== 5'b00101) begin
      bad++; $display("FAIL basic_done got=%b want=00101", {a_so, a_fr, a_done, a_ready, a_busy});
    end
    tick();  // k+10
    total++;
    if ({a_done, a_ready, a_busy} !== 3'b010) begin
      bad++; $display("FAIL basic_ready got=%b want=010", {a_done, a_ready, a_busy});
    end
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    logic       pbit  [2];
    words[0] = 8'hA5; pbit[0] = 1'b0;
    words[1] = 8'h07; pbit[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      p_valid = 1; p_data = words[n];
      tick();
      p_valid = 0;
      for (int i = 0; i < 8; i++) begin
        total++;
        if ({p_so, p_fr} !== {words[n][7-i], 1'b1}) begin
          bad++; $display("FAIL parity_w%0d_bit%0d got=%b want=%b", n, i, {p_so, p_fr}, {words[n][7-i], 1'b1});
        end
        tick();
      end
      total++;  // k+9: parity bit
      if ({p_so, p_fr, p_done} !== {pbit[n], 2'b10}) begin
        bad++; $display("FAIL parity_w%0d_pbit got=%b want=%b", n, {p_so, p_fr, p_done}, {pbit[n], 2'b10});
      end
      tick();  // k+10
      total++;
      if ({p_so, p_fr, p_done} !== 3'b001) begin
        bad++; $display("FAIL parity_w%0d_done got=%b want=001", n, {p_so, p_fr, p_done});
      end
      tick();
    end
  endtask

  task automatic test_bit_cycles();
    logic exp;
    c_valid = 1; c_data = 8'h81;
    tick();
    c_valid = 0;
    for (int j = 0; j < 24; j++) begin
      exp = (j < 3) || (j >= 21);
      total++;
      if ({c_so, c_fr, c_done} !== {exp, 2'b10}) begin
        bad++; $display("FAIL bitcyc_cyc%0d got=%b want=%b", j, {c_so, c_fr, c_done}, {exp, 2'b10});
      end
      tick();
    end
    total++;
    if ({c_so, c_fr, c_done} !== 3'b001) begin
      bad++; $display("FAIL bitcyc_done got=%b want=001", {c_so, c_fr, c_done});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0, w1;
    w0 = 8'h3C; w1 = 8'hC3;
    a_valid = 1; a_data = w0;
    tick();  // k+1
    a_data = w1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({a_so, a_fr} !== {w0[7-i], 1'b1}) begin
        bad++; $display("FAIL b2b_f0_bit%0d got=%b want=%b", i, {a_so, a_fr}, {w0[7-i], 1'b1});
      end
      tick();
    end
    total++;  // k+9: DONE, no accept yet
    if ({a_fr, a_done, a_ready} !== 3'b010) begin
      bad++; $display("FAIL b2b_gap1 got=%b want=010", {a_fr, a_done, a_ready});
    end
    tick();  // k+10: accept cycle
    total++;
    if ({a_fr, a_done, a_ready} !== 3'b001) begin
      bad++; $display("FAIL b2b_gap2 got=%b want=001", {a_fr, a_done, a_ready});
    end
    tick();  // k+11
    a_valid = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({a_so, a_fr} !== {w1[7-i], 1'b1}) begin
        bad++; $display("FAIL b2b_f1_bit%0d got=%b want=%b", i, {a_so, a_fr}, {w1[7-i], 1'b1});
      end
      tick();
    end
    total++;
    if ({a_fr, a_done} !== 2'b01) begin
      bad++; $display("FAIL b2b_done got=%b want=01", {a_fr, a_done});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    a_valid = 1; a_data = 8'hFF;
    tick();  // bit 0
    a_valid = 0;
    repeat (4) tick();  // bit 4
    total++;
    if ({a_so, a_fr, a_busy} !== 3'b111) begin
      bad++; $display("FAIL midrst_pre got=%b want=111", {a_so, a_fr, a_busy});
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({a_so, a_fr, a_busy, a_ready, a_done} !== 5'b00000) begin
      bad++; $display("FAIL midrst_async got=%b want=00000", {a_so, a_fr, a_busy, a_ready, a_done});
    end
    #2 reset = 1'b0;
    tick();
    total++;
    if ({a_ready, a_busy, a_fr} !== 3'b100) begin
      bad++; $display("FAIL midrst_release got=%b want=100", {a_ready, a_busy, a_fr});
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({a_done, a_fr} !== 2'b00) begin
        bad++; $display("FAIL midrst_quiet%0d got=%b want=00", i, {a_done, a_fr});
      end
      tick();
    end
    w = 8'h55;
    a_valid = 1; a_data = w;
    tick();
    a_valid = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({a_so, a_fr} !== {w[7-i], 1'b1}) begin
        bad++; $display("FAIL midrst_new_bit%0d got=%b want=%b", i, {a_so, a_fr}, {w[7-i], 1'b1});
      end
      tick();
    end
    total++;
    if ({a_fr, a_done} !== 2'b01) begin
      bad++; $display("FAIL midrst_new_done got=%b want=01", {a_fr, a_done});
    end
    tick();
  endtask

  task automatic test_ignore();
    logic [7:0] w;
    w = 8'h96;
    a_valid = 1; a_data = w;
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({a_so, a_fr, a_ready} !== {w[7-i], 2'b10}) begin
        bad++; $display("FAIL ignore_bit%0d got=%b want=%b", i, {a_so, a_fr, a_ready}, {w[7-i], 2'b10});
      end
      a_data  = ~a_data;
      a_valid = (i % 2 == 1) && (i < 7);
      tick();
    end
    total++;
    if ({a_fr, a_done} !== 2'b01) begin
      bad++; $display("FAIL ignore_done got=%b want=01", {a_fr, a_done});
    end
    tick();
    tick();
    total++;
    if ({a_busy, a_fr, a_ready} !== 3'b001) begin
      bad++; $display("FAIL ignore_no_extra got=%b want=001", {a_busy, a_fr, a_ready});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_bit_cycles();
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
